// File: rtl/tx_lane_scheduler.sv
// Four-lane round-robin byte scheduler with SYNC/ACTIVE link bring-up.
// Define TX_SCHED_BURST_EN to allow up to BURST_MAX consecutive grants per lane.
module tx_lane_scheduler #(
  parameter int unsigned SYNC_WORDS = 4,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic [3:0] lane_valid,
  input  logic [7:0] lane_data0,
  input  logic [7:0] lane_data1,
  input  logic [7:0] lane_data2,
  input  logic [7:0] lane_data3,
  output logic [3:0] lane_pop,
  input  logic       ser_ready,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic       active
);

  localparam logic ST_SYNC   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  localparam logic [7:0] SYNC_CHAR = 8'hBC;
  localparam logic [7:0] IDLE_CHAR = 8'h7C;

  logic       r_state;
  logic [7:0] r_sync_cnt;
  logic [1:0] r_ptr;
  logic [7:0] r_data;
  logic       r_valid;
  logic [1:0] r_lane;
  logic       r_active;

  logic       w_found;
  logic [1:0] w_grant;
  logic [7:0] w_grant_data;
  logic       w_pop_en;
  logic [1:0] w_ptr_nxt;

`ifdef TX_SCHED_BURST_EN
  logic [3:0] r_burst;
  logic [4:0] w_burst_base;
  logic [4:0] w_burst_inc;
  logic [3:0] w_burst_nxt;
`endif

  // First valid lane scanning upward from the pointer, wrapping mod 4.
  always_comb begin
    w_found = 1'b0;
    w_grant = r_ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!w_found && lane_valid[2'(r_ptr + 2'(k))]) begin
        w_found = 1'b1;
        w_grant = 2'(r_ptr + 2'(k));
      end
    end
  end

  always_comb begin
    w_grant_data = lane_data0;
    case (w_grant)
      2'd0:    w_grant_data = lane_data0;
      2'd1:    w_grant_data = lane_data1;
      2'd2:    w_grant_data = lane_data2;
      default: w_grant_data = lane_data3;
    endcase
  end

  assign w_pop_en = (r_state == ST_ACTIVE) && ser_ready && tx_enable && w_found;
  assign lane_pop = w_pop_en ? (4'b0001 << w_grant) : '0;

`ifdef TX_SCHED_BURST_EN
  // A nonzero count always belongs to the lane in r_lane, so a new lane restarts at zero.
  always_comb begin
    w_burst_base = (w_grant == r_lane && r_burst != '0) ? {1'b0, r_burst} : '0;
    w_burst_inc  = w_burst_base + 5'd1;
    if (w_burst_inc < 5'(BURST_MAX)) begin
      w_ptr_nxt   = w_grant;
      w_burst_nxt = w_burst_inc[3:0];
    end else begin
      w_ptr_nxt   = w_grant + 2'd1;
      w_burst_nxt = '0;
    end
  end
`else
  assign w_ptr_nxt = w_grant + 2'd1;
`endif

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_SYNC;
      r_sync_cnt <= '0;
      r_ptr      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_lane     <= '0;
      r_active   <= 1'b0;
`ifdef TX_SCHED_BURST_EN
      r_burst    <= '0;
`endif
    end else if (r_state == ST_ACTIVE && !tx_enable) begin
      r_state    <= ST_SYNC;
      r_active   <= 1'b0;
      r_sync_cnt <= '0;
`ifdef TX_SCHED_BURST_EN
      r_burst    <= '0;
`endif
      if (ser_ready) begin
        r_data  <= SYNC_CHAR;
        r_valid <= 1'b0;
      end
    end else if (ser_ready) begin
      if (r_state == ST_SYNC) begin
        r_valid <= 1'b0;
        if (r_sync_cnt < 8'(SYNC_WORDS)) begin
          r_data     <= SYNC_CHAR;
          r_sync_cnt <= r_sync_cnt + 8'd1;
        end else if (tx_enable) begin
          r_state  <= ST_ACTIVE;
          r_active <= 1'b1;
          r_data   <= IDLE_CHAR;
        end else begin
          r_data <= SYNC_CHAR;
        end
      end else if (w_found) begin
        r_data  <= w_grant_data;
        r_valid <= 1'b1;
        r_lane  <= w_grant;
        r_ptr   <= w_ptr_nxt;
`ifdef TX_SCHED_BURST_EN
        r_burst <= w_burst_nxt;
`endif
      end else begin
        r_data  <= IDLE_CHAR;
        r_valid <= 1'b0;
`ifdef TX_SCHED_BURST_EN
        r_burst <= '0;
`endif
      end
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign lane_out  = r_lane;
  assign active    = r_active;

endmodule

// File: doc/tx_lane_scheduler.md
# tx_lane_scheduler

Round-robin scheduler that shares the single transmit serializer of the PHY TX path among four byte lanes. Each cycle it grants at most one lane, pops one byte from it and presents that byte to the serializer, tagged with its lane number. It also owns link bring-up: after reset, or whenever transmission is disabled, it sends a run of sync characters before any lane traffic goes out. Idle characters fill the gaps when no lane has data.

## Interface

Parameters:
- SYNC_WORDS, 4: number of 0xBC sync bytes sent before entering ACTIVE; legal range 1..255.
- BURST_MAX, 4: maximum consecutive grants to one lane, used only with burst mode; legal range 1..15.

Ports:
- clk_4f  in  1  byte clock, single clock domain.
- reset  in  1  asynchronous, active-low reset.
- tx_enable  in  1  high allows lane traffic; low forces SYNC.
- lane_valid  in  4  bit i high means lane i has a byte available.
- lane_data0..lane_data3  in  8 each  byte offered by lane 0..3.
- lane_pop  out  4  one-hot or zero; combinational pop strobe to the lane sources.
- ser_ready  in  1  serializer accepts a byte this cycle.
- data_out  out  8  registered byte to the serializer.
- valid_out  out  1  high means data_out carries lane data; low means sync or idle.
- lane_out  out  2  lane number of data_out; meaningful only when valid_out is high.
- active  out  1  high while in ACTIVE.

## Operation

States: SYNC, ACTIVE.
- SYNC
  - Each cycle with ser_ready=1: data_out←0xBC, valid_out←0, sync_cnt increments.
  - When the SYNC_WORDS-th byte is loaded and tx_enable=1, move to ACTIVE on the next edge.
  - If tx_enable=0 when sync_cnt has reached SYNC_WORDS, hold in SYNC and keep sending 0xBC.
- ACTIVE
  - Arbitration is combinational. Starting at pointer ptr, the first lane i (ptr, ptr+1, … mod 4) with lane_valid[i]=1 is granted.
  - lane_pop[i]=1 only when state=ACTIVE, ser_ready=1, tx_enable=1 and lane i is granted.
  - On a grant: data_out←lane_data_i, valid_out←1, lane_out←i, ptr←(i+1) mod 4.
  - No lane valid: data_out←0x7C, valid_out←0, ptr unchanged.
  - tx_enable=0: no pop. Next state is SYNC with sync_cnt←0, and data_out←0xBC if ser_ready=1.
- ser_ready=0 in any state: no pop, all registers hold, and no state change except the tx_enable-driven ACTIVE→SYNC transition.
- active equals (state==ACTIVE) and is registered.
- Reset values: state=SYNC, sync_cnt=0, ptr=0, burst_cnt=0, data_out=0x00, valid_out=0, lane_out=0, active=0. lane_pop is 0 throughout reset.
- Reset asserted mid-transfer discards the in-flight byte. The lane has already seen its pop, so the byte is lost, and this is accepted behaviour.

## Timing

- Pop-to-output latency is 1 cycle: the byte popped in cycle N appears on data_out/valid_out/lane_out after edge N.
- Throughput is one byte per cycle while ser_ready=1.
- First lane byte after reset release: sync_cnt reaches SYNC_WORDS after SYNC_WORDS ready cycles, then one more cycle enters ACTIVE.
  - Earliest valid_out=1 is at edge SYNC_WORDS+2 after reset deassertion when ser_ready is held high.
- lane_pop depends combinationally on lane_valid, ser_ready, tx_enable and registered state. No path runs from lane_pop back to lane_valid inside the block.

## Configuration

- TX_SCHED_BURST_EN undefined: strict round-robin, one byte per grant, ptr always advances past the granted lane. BURST_MAX is ignored.
- TX_SCHED_BURST_EN defined: a 4-bit burst_cnt is added, and the pointer update depends on burst length.
  - After a grant to lane i, if burst_cnt+1 < BURST_MAX then ptr←i and burst_cnt increments.
  - Otherwise ptr←(i+1) mod 4 and burst_cnt←0.
  - A grant to a different lane than the previous grant restarts the count, so burst_cnt becomes 1, or 0 with a pointer advance if BURST_MAX=1.
  - An idle cycle clears burst_cnt.

## Test plan

- Reset release, ser_ready=1, tx_enable=1, no lane valid: expect 4 cycles of data_out=0xBC with valid_out=0, then active=1 and data_out=0x7C.
- All four lanes valid with data 0xA0..0xA3 (burst off): expect lane_out 0,1,2,3,0… on consecutive cycles, with lane_pop one-hot rotating and data matching.
- Lanes 1 and 3 valid only: expect alternating lane_out 1,3,1,3, and lane_pop never asserted for lanes 0 or 2.
- ser_ready low for 3 cycles mid-stream: expect lane_pop=0 and data_out/valid_out/lane_out frozen, then resumption at the next lane in order.
- tx_enable dropped in ACTIVE: expect no pop, active=0 next cycle, then 4 bytes of 0xBC after tx_enable returns high before any valid_out=1.
- TX_SCHED_BURST_EN defined, BURST_MAX=2, all lanes valid: expect lane_out 0,0,1,1,2,2,3,3.
